// File: rtl/mold_msg_arb.sv
`default_nettype none
// ============================================================================
// Module   : mold_msg_arb
// Purpose  : Two-lane MoldUDP64 message arbiter. Each lane pushes beats into
//            its own DEPTH-entry FIFO (no backpressure towards the source).
//            A round-robin arbiter grants whole messages, so beats from the
//            two lanes are never interleaved within a message.
// Ports    : clk, nreset (sync, active-low)
//            lN_msg_{v,start,last,len,mask,data}_i : lane N input beat
//            out_{valid,start,last,len,mask,data,lane}_o, out_ready_i : output
//            overflow_o  : sticky per-lane drop flag (FIFO full)
//            proto_err_o : sticky per-lane flag (non-start beat at idle head)
// Revision : 1.0 - initial release
// ============================================================================
module mold_msg_arb #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = 8,
  parameter int ML_W       = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  l0_msg_v_i,
  input  logic                  l0_msg_start_i,
  input  logic                  l0_msg_last_i,
  input  logic [ML_W-1:0]       l0_msg_len_i,
  input  logic [AXI_KEEP_W-1:0] l0_msg_mask_i,
  input  logic [AXI_DATA_W-1:0] l0_msg_data_i,
  input  logic                  l1_msg_v_i,
  input  logic                  l1_msg_start_i,
  input  logic                  l1_msg_last_i,
  input  logic [ML_W-1:0]       l1_msg_len_i,
  input  logic [AXI_KEEP_W-1:0] l1_msg_mask_i,
  input  logic [AXI_DATA_W-1:0] l1_msg_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_start_o,
  output logic                  out_last_o,
  output logic [ML_W-1:0]       out_len_o,
  output logic [AXI_KEEP_W-1:0] out_mask_o,
  output logic [AXI_DATA_W-1:0] out_data_o,
  output logic                  out_lane_o,
  output logic [1:0]            overflow_o,
  output logic [1:0]            proto_err_o
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_PW = C_AW + 1;
  localparam int C_EW = 2 + ML_W + AXI_KEEP_W + AXI_DATA_W;
  localparam logic [C_PW-1:0] C_DEPTH = C_PW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  logic [1:0]      in_v_w;
  logic [C_EW-1:0] in_ent_w   [2];
  logic [C_EW-1:0] head_w     [2];
  logic [1:0]      ne_w;
  logic [1:0]      head_start_w;
  logic [1:0]      head_last_w;
  logic [1:0]      pop_w;
  logic [1:0]      drop_w;
  logic [1:0]      perr_set_w;
  logic            win_w;
  logic            sel_w;
  logic            out_v_w;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic [1:0]      overflow_q, overflow_d;
  logic [1:0]      proto_err_q, proto_err_d;

  assign in_v_w      = {l1_msg_v_i, l0_msg_v_i};
  assign in_ent_w[0] = {l0_msg_start_i, l0_msg_last_i, l0_msg_len_i, l0_msg_mask_i, l0_msg_data_i};
  assign in_ent_w[1] = {l1_msg_start_i, l1_msg_last_i, l1_msg_len_i, l1_msg_mask_i, l1_msg_data_i};

  // Per-lane FIFO. A full FIFO still accepts a push when it pops the same
  // cycle, since the slot being freed is the one the write pointer reuses.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [C_EW-1:0] mem_q [DEPTH];
    logic [C_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_PW-1:0] count_q, count_d;
    logic            full_w;
    logic            push_w;

    assign full_w    = (count_q == C_DEPTH);
    assign push_w    = in_v_w[g] && (!full_w || pop_w[g]);
    assign drop_w[g] = in_v_w[g] && full_w && !pop_w[g];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_w)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_w[g]) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_w, pop_w[g]})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!nreset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage is not reset; the count guards against reading stale entries.
    always_ff @(posedge clk) begin
      if (push_w) mem_q[wr_ptr_q[C_AW-1:0]] <= in_ent_w[g];
    end

    assign head_w[g]       = mem_q[rd_ptr_q[C_AW-1:0]];
    assign ne_w[g]         = (count_q != '0);
    assign head_start_w[g] = head_w[g][C_EW-1];
    assign head_last_w[g]  = head_w[g][C_EW-2];
  end

  // Tie goes to the lane that did not complete the most recent message.
  assign win_w = (ne_w == 2'b11) ? ~rr_q : ne_w[1];

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    pop_w      = 2'b00;
    perr_set_w = 2'b00;
    sel_w      = 1'b0;
    out_v_w    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_w = win_w;
        if (|ne_w) begin
          if (!head_start_w[win_w]) begin
            // Orphan continuation beat: discard it silently and flag it.
            pop_w[win_w]      = 1'b1;
            perr_set_w[win_w] = 1'b1;
          end else begin
            out_v_w = 1'b1;
            if (out_ready_i && head_last_w[win_w]) begin
              pop_w[win_w] = 1'b1;
              rr_d         = win_w;
            end else begin
              // Lock whether or not the beat was taken so the presented
              // beat cannot switch lanes while waiting for ready.
              pop_w[win_w] = out_ready_i;
              state_d      = win_w ? ST_LOCK1 : ST_LOCK0;
            end
          end
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        sel_w   = (state_q == ST_LOCK1);
        out_v_w = ne_w[sel_w];
        if (ne_w[sel_w] && out_ready_i) begin
          pop_w[sel_w] = 1'b1;
          if (head_last_w[sel_w]) begin
            state_d = ST_IDLE;
            rr_d    = sel_w;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign overflow_d  = overflow_q | drop_w;
  assign proto_err_d = proto_err_q | perr_set_w;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b1;
      overflow_q  <= 2'b00;
      proto_err_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_valid_o = out_v_w;
  assign out_lane_o  = sel_w;
  assign {out_start_o, out_last_o, out_len_o, out_mask_o, out_data_o} = head_w[sel_w];
  assign overflow_o  = overflow_q;
  assign proto_err_o = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mold_msg_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mold_msg_arb
// Purpose  : Directed, table-driven bench for mold_msg_arb plus hand-written
//            sequences for overflow and mid-message reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mold_msg_arb;

  logic        clk = 1'b0;
  logic        nreset;
  logic        l0_v, l0_s, l0_l, l1_v, l1_s, l1_l;
  logic [15:0] l0_len, l1_len;
  logic [7:0]  l0_mask, l1_mask;
  logic [63:0] l0_data, l1_data;
  logic        out_valid, out_ready, out_start, out_last, out_lane;
  logic [15:0] out_len;
  logic [7:0]  out_mask;
  logic [63:0] out_data;
  logic [1:0]  overflow, proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mold_msg_arb dut (
    .clk            (clk),
    .nreset         (nreset),
    .l0_msg_v_i     (l0_v),
    .l0_msg_start_i (l0_s),
    .l0_msg_last_i  (l0_l),
    .l0_msg_len_i   (l0_len),
    .l0_msg_mask_i  (l0_mask),
    .l0_msg_data_i  (l0_data),
    .l1_msg_v_i     (l1_v),
    .l1_msg_start_i (l1_s),
    .l1_msg_last_i  (l1_l),
    .l1_msg_len_i   (l1_len),
    .l1_msg_mask_i  (l1_mask),
    .l1_msg_data_i  (l1_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_start_o    (out_start),
    .out_last_o     (out_last),
    .out_len_o      (out_len),
    .out_mask_o     (out_mask),
    .out_data_o     (out_data),
    .out_lane_o     (out_lane),
    .overflow_o     (overflow),
    .proto_err_o    (proto_err)
  );

  typedef struct {
    logic        v;
    logic        s;
    logic        l;
    logic [15:0] len;
    logic [7:0]  mask;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    beat_t      l0;
    beat_t      l1;
    logic       rdy;
    logic       ev;
    logic       el;
    beat_t      eb;
    logic [1:0] eovf;
    logic [1:0] eperr;
  } row_t;

  function automatic beat_t bt(logic v, logic s, logic l, logic [15:0] len,
                               logic [7:0] mask, logic [63:0] data);
    beat_t b;
    b.v = v; b.s = s; b.l = l; b.len = len; b.mask = mask; b.data = data;
    return b;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checks.
  task automatic cyc(beat_t b0, beat_t b1, logic rdy, logic rst_n);
    @(negedge clk);
    nreset    = rst_n;
    out_ready = rdy;
    l0_v = b0.v; l0_s = b0.s; l0_l = b0.l; l0_len = b0.len; l0_mask = b0.mask; l0_data = b0.data;
    l1_v = b1.v; l1_s = b1.s; l1_l = b1.l; l1_len = b1.len; l1_mask = b1.mask; l1_data = b1.data;
    #1;
  endtask

  task automatic chk_beat(string nm, logic lane, beat_t e);
    chk({nm, ".valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".lane"},  64'(out_lane),  64'(lane));
    chk({nm, ".start"}, 64'(out_start), 64'(e.s));
    chk({nm, ".last"},  64'(out_last),  64'(e.l));
    chk({nm, ".len"},   64'(out_len),   64'(e.len));
    chk({nm, ".mask"},  64'(out_mask),  64'(e.mask));
    chk({nm, ".data"},  out_data,       e.data);
  endtask

  row_t  vec[$];
  beat_t nb;

  initial begin
    nb = bt(0, 0, 0, 16'd0, 8'h00, 64'h0);
    // Tie on lanes 0/1 (3-beat each), tie single beats, single beat on lane 0,
    // lane 1 held while not ready, lane 1 orphan beat then a valid message.
    vec.push_back('{bt(1,1,0,24,8'hFF,64'h01), bt(1,1,0,24,8'hFF,64'h11), 1, 0, 0, nb, 2'b00, 2'b00});
    vec.push_back('{bt(1,0,0,0,8'hFF,64'h02),  bt(1,0,0,0,8'hFF,64'h12),  1, 1, 0, bt(1,1,0,24,8'hFF,64'h01), 2'b00, 2'b00});
    vec.push_back('{bt(1,0,1,0,8'hFF,64'h03),  bt(1,0,1,0,8'hFF,64'h13),  1, 1, 0, bt(1,0,0,0,8'hFF,64'h02), 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 0, bt(1,0,1,0,8'hFF,64'h03),  2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 1, bt(1,1,0,24,8'hFF,64'h11), 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 1, bt(1,0,0,0,8'hFF,64'h12),  2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 1, bt(1,0,1,0,8'hFF,64'h13),  2'b00, 2'b00});
    vec.push_back('{bt(1,1,1,1,8'h01,64'h21), bt(1,1,1,1,8'h01,64'h31), 1, 0, 0, nb, 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 0, bt(1,1,1,1,8'h01,64'h21), 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 1, bt(1,1,1,1,8'h01,64'h31), 2'b00, 2'b00});
    vec.push_back('{bt(1,1,1,5,8'h1F,64'hAA), nb, 1, 0, 0, nb, 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 0, bt(1,1,1,5,8'h1F,64'hAA), 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 0, 0, nb, 2'b00, 2'b00});
    vec.push_back('{nb, bt(1,1,1,8,8'hFF,64'h41), 0, 0, 0, nb, 2'b00, 2'b00});
    vec.push_back('{bt(1,1,1,8,8'hFF,64'h51), nb, 0, 1, 1, bt(1,1,1,8,8'hFF,64'h41), 2'b00, 2'b00});
    vec.push_back('{nb, nb, 0, 1, 1, bt(1,1,1,8,8'hFF,64'h41), 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 1, bt(1,1,1,8,8'hFF,64'h41), 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 1, 0, bt(1,1,1,8,8'hFF,64'h51), 2'b00, 2'b00});
    vec.push_back('{nb, bt(1,0,0,0,8'hFF,64'h61), 1, 0, 0, nb, 2'b00, 2'b00});
    vec.push_back('{nb, nb, 1, 0, 0, nb, 2'b00, 2'b00});
    vec.push_back('{nb, bt(1,1,1,2,8'h03,64'h71), 1, 0, 0, nb, 2'b00, 2'b10});
    vec.push_back('{nb, nb, 1, 1, 1, bt(1,1,1,2,8'h03,64'h71), 2'b00, 2'b10});
    vec.push_back('{nb, nb, 1, 0, 0, nb, 2'b00, 2'b10});

    nreset = 1'b0; out_ready = 1'b0;
    l0_v = 0; l0_s = 0; l0_l = 0; l0_len = '0; l0_mask = '0; l0_data = '0;
    l1_v = 0; l1_s = 0; l1_l = 0; l1_len = '0; l1_mask = '0; l1_data = '0;
    repeat (2) @(posedge clk);

    foreach (vec[i]) begin
      cyc(vec[i].l0, vec[i].l1, vec[i].rdy, 1'b1);
      if (vec[i].ev) chk_beat($sformatf("v%0d", i), vec[i].el, vec[i].eb);
      else           chk($sformatf("v%0d.valid", i), 64'(out_valid), 64'd0);
      chk($sformatf("v%0d.ovf", i),  64'(overflow),  64'(vec[i].eovf));
      chk($sformatf("v%0d.perr", i), 64'(proto_err), 64'(vec[i].eperr));
    end

    // Overflow: five lane-0 beats while not ready; the fifth is dropped.
    for (int k = 0; k < 5; k++) begin
      cyc(bt(1, (k == 0) || (k == 4), (k == 3) || (k == 4), 16'(k), 8'hFF, 64'h100 + 64'(k)),
          nb, 1'b0, 1'b1);
      if (k == 0) chk("ovf.wait0.valid", 64'(out_valid), 64'd0);
      else        chk_beat($sformatf("ovf.hold%0d", k), 1'b0, bt(1,1,0,0,8'hFF,64'h100));
      chk($sformatf("ovf.pre%0d", k), 64'(overflow), 64'd0);
    end
    for (int j = 0; j < 4; j++) begin
      cyc(nb, nb, 1'b1, 1'b1);
      chk_beat($sformatf("ovf.drain%0d", j), 1'b0,
               bt(1, j == 0, j == 3, 16'(j), 8'hFF, 64'h100 + 64'(j)));
      chk($sformatf("ovf.flag%0d", j), 64'(overflow), 64'd1);
    end
    cyc(nb, nb, 1'b1, 1'b1);
    chk("ovf.empty.valid", 64'(out_valid), 64'd0);
    chk("ovf.sticky", 64'(overflow), 64'd1);

    // Reset during the second beat of a 3-beat lane-0 message.
    cyc(bt(1,1,0,24,8'hFF,64'h200), nb, 1'b1, 1'b1);
    chk("rst.pre.valid", 64'(out_valid), 64'd0);
    cyc(bt(1,0,0,0,8'hFF,64'h201), nb, 1'b1, 1'b0);
    chk_beat("rst.beat1", 1'b0, bt(1,1,0,24,8'hFF,64'h200));
    cyc(nb, bt(1,1,1,3,8'h07,64'h81), 1'b1, 1'b1);
    chk("rst.post.valid", 64'(out_valid), 64'd0);
    chk("rst.post.ovf",   64'(overflow),  64'd0);
    chk("rst.post.perr",  64'(proto_err), 64'd0);
    cyc(nb, nb, 1'b1, 1'b1);
    chk_beat("rst.l1msg", 1'b1, bt(1,1,1,3,8'h07,64'h81));
    cyc(nb, nb, 1'b1, 1'b1);
    chk("rst.end.valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mold_msg_arb.md
MOLD_MSG_ARB -- requirements
Module: mold_msg_arb

Interface
REQ-001 Parameter AXI_DATA_W, default 64: message data width in bits.
REQ-002 Parameter AXI_KEEP_W, default 8: byte mask width, AXI_DATA_W/8.
REQ-003 Parameter ML_W, default 16: MoldUDP64 message length field width.
REQ-004 Parameter DEPTH, default 4, power of 2: per-lane FIFO depth in beats.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 nreset  in  1  reset, synchronous, active-low.
REQ-007 lN_msg_v_i  in  1  lane N (N=0,1) beat valid; no backpressure, the source cannot stall.
REQ-008 lN_msg_start_i  in  1  lane N first beat of a message.
REQ-009 lN_msg_last_i  in  1  lane N last beat of a message; start and last both high marks a single-beat message.
REQ-010 lN_msg_len_i  in  ML_W  lane N message length in bytes, meaningful with start.
REQ-011 lN_msg_mask_i  in  AXI_KEEP_W  lane N byte-valid mask.
REQ-012 lN_msg_data_i  in  AXI_DATA_W  lane N data.
REQ-013 out_valid_o  out  1  output beat valid.
REQ-014 out_ready_i  in  1  downstream accepts; a transfer occurs when valid and ready are both high.
REQ-015 out_start_o, out_last_o, out_len_o, out_mask_o, out_data_o  out  1/1/ML_W/AXI_KEEP_W/AXI_DATA_W  fields of the granted beat.
REQ-016 out_lane_o  out  1  index of the lane that sources the current beat.
REQ-017 overflow_o  out  2  sticky per-lane flag, set when a beat is dropped because its FIFO is full.
REQ-018 proto_err_o  out  2  sticky per-lane flag, set when a non-start beat reaches the head of an idle lane.

Function
REQ-019 Each lane SHALL have its own DEPTH-entry FIFO storing {start,last,len,mask,data}, with pointers and occupancy count of width clog2(DEPTH)+1.
REQ-020 A valid input beat SHALL be written at the clock edge and SHALL be visible at the FIFO head the following cycle, giving 1-cycle minimum input-to-output latency.
REQ-021 A push to a full FIFO SHALL drop the beat and set overflow_o[N], unless the same lane pops in that cycle, in which case the push SHALL succeed.
REQ-022 The arbiter SHALL be a 3-state FSM: IDLE, LOCK0, LOCK1.
REQ-023 In IDLE, the winner SHALL be the non-empty lane, or, if both lanes are non-empty, lane ~rr_q, where rr_q holds the last lane to complete a message (reset value 1, so lane 0 wins first).
REQ-024 In IDLE with a winner, out_valid_o SHALL be driven from the winner's head the same cycle.
  - If the head is accepted and is last: stay IDLE, set rr_q to the winner.
  - Otherwise: go to LOCKwinner. This covers both "not accepted" and "accepted, not last", so a presented beat never changes while waiting for ready.
REQ-025 In LOCKx, only lane x SHALL be presented; out_valid_o = lane x non-empty. On an accepted beat with last set: go to IDLE and set rr_q=x.
REQ-026 Another lane's beats SHALL NOT be interleaved inside a message.
REQ-027 In IDLE, a winner head with start=0 SHALL be popped without being output and SHALL set proto_err_o[N].
  - out_valid_o stays 0 that cycle.
  - The FSM stays in IDLE.
REQ-028 out_lane_o SHALL equal the sourcing lane whenever out_valid_o=1; all out_* fields are don't-care when out_valid_o=0.
REQ-029 Pop, push and the FSM transition in the same cycle SHALL all take effect at that edge.
REQ-030 Throughput: one beat per cycle with out_ready_i held high, including back-to-back messages from alternating lanes with no bubble.

Reset
REQ-031 While nreset=0 at a clock edge, the block SHALL clear both FIFOs (count 0, pointers 0), set FSM=IDLE, rr_q=1, overflow_o=0 and proto_err_o=0.
REQ-032 The cycle after reset, out_valid_o SHALL be 0; FIFO data storage needs no reset.
REQ-033 Reset asserted mid-message SHALL discard all buffered beats and the lock; input beats present during reset SHALL NOT be stored.

Verification
REQ-034 Single-beat message on lane 0 (start=last=1, len=5, mask=0x1F, data=0xAA), ready=1 -> 1 cycle later out_valid_o=1, out_lane_o=0, out_len_o=5, out_mask_o=0x1F; FSM stays IDLE.
REQ-035 Lane 0 and lane 1 each start a 3-beat message in the same cycle, ready=1 -> lane 0 beats 1,2,3 then lane 1 beats 1,2,3 on consecutive cycles, no interleave; next tie goes to lane 0.
REQ-036 Lane 1 head presented in IDLE with ready=0, then lane 0 becomes non-empty -> lane 1 beat held stable until ready rises; lane 0 waits.
REQ-037 ready=0 while lane 0 receives 5 consecutive beats (DEPTH=4) -> 5th beat dropped, overflow_o=2'b01 sticky; releasing ready outputs exactly beats 1-4.
REQ-038 Lane 1 first beat has start=0 -> beat never appears on output, proto_err_o=2'b10.
REQ-039 Reset pulsed during the second beat of a 3-beat lane-0 message -> out_valid_o=0 next cycle, FIFOs empty, both flags 0; a new message from lane 1 is then granted normally.
